// File: rtl/lector_salidas.sv
// Round-robin drain reader for output FIFOs 4..7 feeding one ready-gated sink, with per-channel delivered-word counters.
// Define LECTOR_CNT_SAT_EN to make counters saturate at all-ones; otherwise they wrap.
module lector_salidas #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] FIFO_data_out4,
  input  logic [DATA_W-1:0] FIFO_data_out5,
  input  logic [DATA_W-1:0] FIFO_data_out6,
  input  logic [DATA_W-1:0] FIFO_data_out7,
  output logic              pop4,
  output logic              pop5,
  output logic              pop6,
  output logic              pop7,
  input  logic              sink_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        ch_out,
  input  logic              IDLE,
  input  logic [1:0]        idx,
  input  logic              req,
  output logic              valid_contador,
  output logic [CNT_W-1:0]  contador_out
);

  typedef enum logic [1:0] {SEL, POP, WAIT} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  rr_q, rr_d;
  logic [1:0]                  gnt_q, gnt_d;
  logic [3:0]                  pop_q, pop_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic                        valid_q, valid_d;
  logic [1:0]                  ch_q, ch_d;
  logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic                        vcont_q, vcont_d;
  logic [CNT_W-1:0]            cont_q, cont_d;

  logic [DATA_W-1:0]           fifo_rd [4];
  logic [1:0]                  grant;
  logic [1:0]                  cand;
  logic [CNT_W-1:0]            cnt_inc;

  assign fifo_rd[0] = FIFO_data_out4;
  assign fifo_rd[1] = FIFO_data_out5;
  assign fifo_rd[2] = FIFO_data_out6;
  assign fifo_rd[3] = FIFO_data_out7;

  // Scan from the farthest offset down so the nearest non-empty channel to rr_q wins.
  always_comb begin
    grant = rr_q;
    cand  = rr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + k[1:0];
      if (!fifo_empty[cand]) grant = cand;
    end
  end

  always_comb begin
`ifdef LECTOR_CNT_SAT_EN
    cnt_inc = (cnt_q[gnt_q] == '1) ? cnt_q[gnt_q] : cnt_q[gnt_q] + 1'b1;
`else
    cnt_inc = cnt_q[gnt_q] + 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    pop_d   = '0;
    data_d  = data_q;
    valid_d = 1'b0;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEL: begin
        if (!IDLE && sink_ready && (fifo_empty != 4'b1111)) begin
          pop_d[grant] = 1'b1;
          gnt_d        = grant;
          state_d      = POP;
        end
      end
      POP: begin
        rr_d    = gnt_q + 2'd1;
        state_d = WAIT;
      end
      WAIT: begin
        data_d       = fifo_rd[gnt_q];
        ch_d         = gnt_q;
        valid_d      = 1'b1;
        cnt_d[gnt_q] = cnt_inc;
        state_d      = SEL;
      end
      default: state_d = SEL;
    endcase
  end

  // Reads see the registered counters, so a same-cycle increment is not yet visible.
  always_comb begin
    vcont_d = 1'b0;
    cont_d  = cont_q;
    if (req && IDLE) begin
      vcont_d = 1'b1;
      cont_d  = cnt_q[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEL;
      rr_q    <= 2'd0;
      gnt_q   <= 2'd0;
      pop_q   <= 4'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= 2'd0;
      cnt_q   <= '0;
      vcont_q <= 1'b0;
      cont_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      pop_q   <= pop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      vcont_q <= vcont_d;
      cont_q  <= cont_d;
    end
  end

  assign pop4           = pop_q[0];
  assign pop5           = pop_q[1];
  assign pop6           = pop_q[2];
  assign pop7           = pop_q[3];
  assign data_out       = data_q;
  assign valid_out      = valid_q;
  assign ch_out         = ch_q;
  assign valid_contador = vcont_q;
  assign contador_out   = cont_q;

endmodule

// File: tb/tb_lector_salidas.sv
// Directed self-checking bench for lector_salidas with a behavioural model of the four output FIFOs.
// Expected counter values follow LECTOR_CNT_SAT_EN when it is defined.
module tb_lector_salidas;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fifo_empty;
  logic       pop4, pop5, pop6, pop7;
  logic       sink_ready;
  logic [9:0] data_out;
  logic       valid_out;
  logic [1:0] ch_out;
  logic       IDLE;
  logic [1:0] idx;
  logic       req;
  logic       valid_contador;
  logic [4:0] contador_out;

  logic [9:0]      mem [4][256];
  logic [3:0][7:0] wr_ptr = '0;
  logic [3:0][7:0] rd_ptr = '0;
  logic [9:0]      fdata [4] = '{default: 10'd0};
  int              empty_pops = 0;
  logic [3:0]      pops;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign pops = {pop7, pop6, pop5, pop4};
  for (genvar g = 0; g < 4; g++) begin : g_empty
    assign fifo_empty[g] = (rd_ptr[g] == wr_ptr[g]);
  end

  // FIFO model: read data appears the cycle after a pop; popping an empty FIFO is recorded.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pops[i]) begin
        if (rd_ptr[i] == wr_ptr[i]) begin
          empty_pops <= empty_pops + 1;
        end else begin
          fdata[i]  <= mem[i][rd_ptr[i]];
          rd_ptr[i] <= rd_ptr[i] + 8'd1;
        end
      end
    end
  end

  lector_salidas #(.DATA_W(10), .CNT_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .FIFO_data_out4 (fdata[0]),
    .FIFO_data_out5 (fdata[1]),
    .FIFO_data_out6 (fdata[2]),
    .FIFO_data_out7 (fdata[3]),
    .pop4           (pop4),
    .pop5           (pop5),
    .pop6           (pop6),
    .pop7           (pop7),
    .sink_ready     (sink_ready),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .ch_out         (ch_out),
    .IDLE           (IDLE),
    .idx            (idx),
    .req            (req),
    .valid_contador (valid_contador),
    .contador_out   (contador_out)
  );

`ifdef LECTOR_CNT_SAT_EN
  localparam logic [31:0] CNT_AFTER_32 = 32'd31;
  localparam logic [31:0] CNT_AFTER_33 = 32'd31;
`else
  localparam logic [31:0] CNT_AFTER_32 = 32'd0;
  localparam logic [31:0] CNT_AFTER_33 = 32'd1;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [9:0] word);
    mem[ch][wr_ptr[ch]] = word;
    wr_ptr[ch] = wr_ptr[ch] + 8'd1;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Entered on the negedge of the pop cycle; leaves on the negedge of the next grant opportunity.
  task automatic finishWord(input int ch, input logic [9:0] word);
    @(negedge clk);
    checkOutput("wait_quiet", {27'd0, pops, valid_out}, 32'd0);
    @(negedge clk);
    checkOutput("valid_pulse", 32'(valid_out), 32'd1);
    checkOutput("data_out", 32'(data_out), 32'(word));
    checkOutput("ch_out", 32'(ch_out), 32'(ch));
    checkOutput("pop_gap", 32'(pops), 32'd0);
    @(negedge clk);
    checkOutput("valid_drop", 32'(valid_out), 32'd0);
  endtask

  task automatic deliver(input int ch, input logic [9:0] word);
    checkOutput("pop_grant", 32'(pops), 32'd1 << ch);
    finishWord(ch, word);
  endtask

  initial begin
    reset      = 1'b0;
    IDLE       = 1'b1;
    sink_ready = 1'b1;
    req        = 1'b0;
    idx        = 2'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_pops", 32'(pops), 32'd0);
    checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_ch_out", 32'(ch_out), 32'd0);
    checkOutput("rst_valid_contador", 32'(valid_contador), 32'd0);
    checkOutput("rst_contador_out", 32'(contador_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single channel FIFO4");
    push(0, 10'h001); push(0, 10'h002); push(0, 10'h003);
    IDLE = 1'b0;
    @(negedge clk);
    deliver(0, 10'h001);
    deliver(0, 10'h002);
    deliver(0, 10'h003);
    checkOutput("fifo4_drained", 32'(pops), 32'd0);

    $display("[TB] round robin across all channels");
    IDLE = 1'b1;
    applyReset();
    push(0, 10'h001); push(1, 10'h101); push(2, 10'h201); push(3, 10'h301);
    IDLE = 1'b0;
    @(negedge clk);
    deliver(0, 10'h001);
    deliver(1, 10'h101);
    deliver(2, 10'h201);
    deliver(3, 10'h301);
    IDLE = 1'b1;
    push(2, 10'h202); push(0, 10'h002);
    @(negedge clk);
    IDLE = 1'b0;
    @(negedge clk);
    deliver(0, 10'h002);
    deliver(2, 10'h202);

    $display("[TB] sink_ready gating");
    IDLE = 1'b1;
    applyReset();
    sink_ready = 1'b0;
    push(1, 10'h111); push(1, 10'h112);
    IDLE = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("hold_no_ready", 32'(pops), 32'd0);
    end
    sink_ready = 1'b1;
    @(negedge clk);
    checkOutput("pop_after_ready", 32'(pops), 32'b0010);
    sink_ready = 1'b0;
    finishWord(1, 10'h111);
    checkOutput("no_pop_ready_low", 32'(pops), 32'd0);
    sink_ready = 1'b1;
    @(negedge clk);
    deliver(1, 10'h112);

    $display("[TB] counter query");
    IDLE = 1'b1; req = 1'b1; idx = 2'd0;
    @(negedge clk);
    checkOutput("q0_valid", 32'(valid_contador), 32'd1);
    checkOutput("q0_count", 32'(contador_out), 32'd0);
    idx = 2'd1;
    @(negedge clk);
    checkOutput("q1_valid", 32'(valid_contador), 32'd1);
    checkOutput("q1_count", 32'(contador_out), 32'd2);
    IDLE = 1'b0; idx = 2'd0;
    @(negedge clk);
    checkOutput("q_busy_valid", 32'(valid_contador), 32'd0);
    checkOutput("q_busy_hold", 32'(contador_out), 32'd2);
    req = 1'b0;

    $display("[TB] counter overflow on FIFO7");
    IDLE = 1'b1;
    for (int i = 0; i < 33; i++) push(3, 10'(10'h300 + i));
    @(negedge clk);
    IDLE = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) deliver(3, 10'(10'h300 + i));
    checkOutput("pop7_last", 32'(pops), 32'b1000);
    IDLE = 1'b1; req = 1'b1; idx = 2'd3;
    @(negedge clk);
    checkOutput("q3_wait_valid", 32'(valid_contador), 32'd1);
    checkOutput("q3_after32", 32'(contador_out), CNT_AFTER_32);
    @(negedge clk);
    checkOutput("idle_no_abort_valid", 32'(valid_out), 32'd1);
    checkOutput("idle_no_abort_data", 32'(data_out), 32'h320);
    checkOutput("q3_pre_increment", 32'(contador_out), CNT_AFTER_32);
    @(negedge clk);
    checkOutput("q3_after33", 32'(contador_out), CNT_AFTER_33);
    checkOutput("idle_blocks_pop", 32'(pops), 32'd0);
    req = 1'b0;

    $display("[TB] reset during WAIT");
    push(0, 10'h055);
    @(negedge clk);
    IDLE = 1'b0;
    @(negedge clk);
    checkOutput("pop4_inflight", 32'(pops), 32'b0001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("arst_pops", 32'(pops), 32'd0);
    checkOutput("arst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("arst_data_out", 32'(data_out), 32'd0);
    checkOutput("arst_ch_out", 32'(ch_out), 32'd0);
    checkOutput("arst_valid_contador", 32'(valid_contador), 32'd0);
    checkOutput("arst_contador_out", 32'(contador_out), 32'd0);
    @(negedge clk);
    checkOutput("arst_hold_valid", 32'(valid_out), 32'd0);
    reset = 1'b1;
    IDLE  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("discarded_word", 32'(valid_out), 32'd0);
    end
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idx = 2'(i);
      @(negedge clk);
      checkOutput("post_rst_valid", 32'(valid_contador), 32'd1);
      checkOutput("post_rst_count", 32'(contador_out), 32'd0);
    end
    req = 1'b0;

    checkOutput("no_empty_pop", 32'(empty_pops), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lector_salidas.md
# lector_salidas

Drain-side reader for the four output FIFOs (channels 4–7) of the switch datapath. It pops words round-robin from whichever output FIFOs are non-empty and forwards them to a single downstream sink with a ready handshake. It keeps a per-channel count of delivered words, which can be queried through the idx/req counter interface while the system FSM reports IDLE.

## Interface
- DATA_W, 10, word width of FIFO data and sink data
- CNT_W, 5, width of each per-channel delivered-word counter
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- fifo_empty  input  4  empty flags, bit0=FIFO4 … bit3=FIFO7
- FIFO_data_out4..7  input  DATA_W each  FIFO read data, valid the cycle after pop
- pop4..pop7  output  1 each  registered pop strobes, at most one high per cycle
- sink_ready  input  1  downstream can accept a word
- data_out  output  DATA_W  registered forwarded word
- valid_out  output  1  data_out valid, one-cycle pulse per word
- ch_out  output  2  source channel of data_out (0=FIFO4 … 3=FIFO7)
- IDLE  input  1  system FSM in IDLE; blocks popping, enables counter queries
- idx  input  2  counter index for query
- req  input  1  counter query request
- valid_contador  output  1  contador_out valid
- contador_out  output  CNT_W  delivered count of channel idx

## Operation
- Reset values: pop4..7=0, data_out=0, valid_out=0, ch_out=0, valid_contador=0, contador_out=0, all counters=0, RR pointer=0, state=SEL.
- FSM states: SEL, POP, WAIT.
- SEL: if IDLE=1 or sink_ready=0 or fifo_empty=4'b1111, stay in SEL with no pop. Otherwise grant the first non-empty channel starting at the RR pointer, in increasing index order with wrap 3→0. Register pop for that channel and latch the channel number. Go to POP.
- POP: the pop strobe is high for exactly this cycle. Clear it at the end of the cycle. Set RR pointer = granted+1 (mod 4). Go to WAIT.
- WAIT: FIFO_data_out of the granted channel is valid. Register it into data_out, set ch_out to the granted channel, and assert valid_out for the next cycle. Increment counter[granted]. Go to SEL.
- valid_out deasserts after one cycle. data_out and ch_out hold their last values.
- sink_ready is sampled only in SEL. A word already popped is always delivered, even if sink_ready drops.
- Counter query: when req=1 and IDLE=1 in cycle n, valid_contador=1 and contador_out=counter[idx] in cycle n+1. With req=0 or IDLE=0, valid_contador=0 and contador_out holds its value.
- A query in the same cycle as an increment of the same counter returns the pre-increment value.
- Counter width rule: counters are CNT_W bits unsigned. Overflow behaviour is set by the macro below.
- Reset mid-operation: all state clears asynchronously. An in-flight popped word is discarded and pops drop to 0 immediately.

## Timing
- Decision (SEL) in cycle n → pop high in n+1 → data captured in n+2 → valid_out high in n+3.
- Pop-to-valid_out latency is 2 cycles.
- Earliest next pop is n+4, so peak throughput is 1 word per 3 cycles. This guarantees the empty flags reflect the previous pop before the next decision, so a FIFO is never popped while empty.
- IDLE rising while in POP/WAIT does not abort the transaction. It only blocks the next SEL grant.
- Query latency is 1 cycle. Back-to-back req gives back-to-back valid_contador.

## Configuration
- LECTOR_CNT_SAT_EN defined: counters saturate at 2^CNT_W−1 (31) and stay there until reset.
- Not defined: counters wrap modulo 2^CNT_W (31→0).

## Test plan
- Reset, then FIFO4 holds 3 words (0x001,0x002,0x003), others empty, sink_ready=1, IDLE=0 → three pop4 pulses spaced 3 cycles apart; data_out 0x001,0x002,0x003 with ch_out=0, each valid_out 2 cycles after its pop4; pop4 never high while fifo_empty[0]=1.
- All four FIFOs hold 1 word (0x001,0x101,0x201,0x301) → pops in order 4,5,6,7 → outputs in that order. Then refill FIFO6 and FIFO4 → next grant is FIFO4 (pointer wrapped to 0).
- sink_ready=0 with data pending → no pops. Raise sink_ready → pop within 1 cycle. Drop sink_ready during POP → that word is still delivered with valid_out.
- After delivering 2 words on FIFO5, set IDLE=1, idx=1, req=1 → next cycle valid_contador=1, contador_out=2. Same query with IDLE=0 → valid_contador=0.
- Deliver 33 words on FIFO7, then query idx=3 → contador_out=1 without LECTOR_CNT_SAT_EN, 31 with it.
- Assert reset low during the WAIT state → all outputs 0 immediately, no valid_out for the in-flight word, counters 0 after release.
